// File: rtl/rst_seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_gen_pkg
//
// Purpose : Shared definitions for the reset generator / sequencer.
//           Holds the sequencer state type, default parameter values and
//           small constant-evaluation helpers used to size counters.
//
// Contents:
//   state_t         - sequencer state (ASSERT, RELEASE, IDLE)
//   DEF_N_OUT       - default number of sequenced reset outputs
//   DEF_STRETCH     - default minimum all-asserted stretch (cycles)
//   DEF_STAGE_GAP   - default gap between successive releases (cycles)
//   DEF_FILT        - default number of consecutive samples to accept ext req
//   clog2()         - ceiling log2, never smaller than 1 bit
//   max_int()       - larger of two integers
// ---------------------------------------------------------------------------
package rst_seq_gen_pkg;

    // ASSERT  : every output held high, stretch counter running
    // RELEASE : outputs dropping one at a time, gap counter running
    // IDLE    : all outputs released, waiting for the next request
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        IDLE    = 2'd2
    } state_t;

    localparam int DEF_N_OUT     = 4;
    localparam int DEF_STRETCH   = 16;
    localparam int DEF_STAGE_GAP = 4;
    localparam int DEF_FILT      = 3;

    // Returns the number of bits needed to index 'value' distinct codes.
    // A minimum of one bit keeps degenerate parameter choices legal vectors.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_gen_filter.sv
// ---------------------------------------------------------------------------
// rst_req_filter
//
// Purpose : Brings the asynchronous external reset request into the clk
//           domain through a 2-flop synchroniser, then debounces it: the
//           request is only accepted after FILT consecutive synchronised
//           high samples. Any low sample throws the accumulated count away.
//
// Ports   :
//   clk          in   sole clock
//   rst          in   synchronous active-high reset, clears sync + counter
//   ext_rst_req  in   raw asynchronous request level
//   ext_f        out  filtered request, high while the count sits at FILT
// ---------------------------------------------------------------------------
module rst_req_filter
    import rst_seq_gen_pkg::*;
#(
    parameter int FILT = DEF_FILT
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_rst_req,
    output logic ext_f
);

    localparam int              CW     = clog2(FILT + 1);
    localparam logic [CW-1:0]   FILT_C = CW'(FILT);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Synchroniser plus saturating run-length counter. The counter stops at
    // FILT so a long request keeps ext_f high instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= ext_rst_req;
            sync_b <= sync_a;
            if (!sync_b) begin
                cnt <= '0;
            end else if (cnt != FILT_C) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign ext_f = (cnt == FILT_C);

endmodule

// File: rtl/rst_seq_gen.sv
// ---------------------------------------------------------------------------
// rst_seq_gen
//
// Purpose : Reset generator and sequencer for one clock domain. Merges the
//           system reset, a filtered external request and a software pulse.
//           All outputs are held asserted until no request has been seen for
//           STRETCH cycles, then rst_out[0], rst_out[1], ... are released in
//           order with STAGE_GAP cycles between releases. A request at any
//           time re-asserts every output together and restarts the stretch.
//
// Ports   :
//   clk          in   sole clock
//   rst          in   synchronous active-high reset
//   ext_rst_req  in   asynchronous external request level (filtered inside)
//   sw_rst_req   in   one-cycle software request pulse, synchronous to clk
//   rst_out      out  N_OUT active-high block resets, bit 0 released first
//   busy         out  high whenever the sequencer is not IDLE
//   done         out  one-cycle pulse on the cycle after the last release
// ---------------------------------------------------------------------------
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int N_OUT     = DEF_N_OUT,
    parameter int STRETCH   = DEF_STRETCH,
    parameter int STAGE_GAP = DEF_STAGE_GAP,
    parameter int FILT      = DEF_FILT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_rst_req,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             busy,
    output logic             done
);

    // One counter serves both the stretch and the inter-stage gap, so it is
    // sized for whichever of the two can run longer.
    localparam int CNT_W = clog2(max_int(STRETCH, STAGE_GAP * N_OUT) + 1);
    localparam int IDX_W = clog2(N_OUT);

    localparam logic [CNT_W-1:0] STRETCH_M1 = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_M1     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_OUT - 1);
    localparam logic [N_OUT-1:0] ALL_ONES   = '1;
    localparam logic [N_OUT-1:0] BIT0       = N_OUT'(1);
    localparam logic [N_OUT-1:0] FIRST_CLR  = ALL_ONES << 1;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic [N_OUT-1:0] rst_out_nx;
    logic             done_nx;
    logic             ext_f;
    logic             req;

    rst_req_filter #(
        .FILT (FILT)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .ext_rst_req (ext_rst_req),
        .ext_f       (ext_f)
    );

    // rst itself is handled by the register reset branch below, which lands
    // in exactly the same place as any other request.
    assign req = ext_f | sw_rst_req;

    // State and output registers. rst_out and done are registered so the
    // downstream resets never see decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= ALL_ONES;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            rst_out <= rst_out_nx;
            done    <= done_nx;
        end
    end

    // Next-state logic. A request is checked first in every state so that it
    // wins over a release scheduled for the same edge; re-assertion therefore
    // always sets every output at once and suppresses the done pulse.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        rst_out_nx = rst_out;
        done_nx    = 1'b0;

        unique case (state)
            ASSERT: begin
                rst_out_nx = ALL_ONES;
                if (req) begin
                    cnt_nx = '0;
                end else if (cnt == STRETCH_M1) begin
                    cnt_nx     = '0;
                    rst_out_nx = FIRST_CLR;
                    if (N_OUT == 1) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RELEASE;
                        idx_nx   = IDX_W'(1);
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (req) begin
                    state_nx   = ASSERT;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    rst_out_nx = ALL_ONES;
                end else if (cnt == GAP_M1) begin
                    cnt_nx     = '0;
                    rst_out_nx = rst_out & ~(BIT0 << idx);
                    if (idx == LAST_IDX) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            IDLE: begin
                rst_out_nx = '0;
                if (req) begin
                    state_nx   = ASSERT;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    rst_out_nx = ALL_ONES;
                end
            end

            default: begin
                state_nx   = ASSERT;
                cnt_nx     = '0;
                idx_nx     = '0;
                rst_out_nx = ALL_ONES;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
